// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arbiter_if                                                  |
// | Purpose  : Fetch, load/store and memory-side signals of mem_arbiter.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if #(
    parameter int WORD_LEN = 32
);
    // Instruction-fetch requester
    logic                i_req;
    logic [WORD_LEN-1:0] i_addr;
    logic                i_gnt;
    logic                i_rvalid;
    logic [WORD_LEN-1:0] i_rdata;

    // Load/store requester
    logic                d_req;
    logic                d_we;
    logic [WORD_LEN-1:0] d_addr;
    logic [WORD_LEN-1:0] d_wdata;
    logic                d_gnt;
    logic                d_rvalid;
    logic [WORD_LEN-1:0] d_rdata;

    // Single-port memory
    logic                m_en;
    logic                m_we;
    logic [WORD_LEN-1:0] m_addr;
    logic [WORD_LEN-1:0] m_wdata;
    logic [WORD_LEN-1:0] m_rdata;

    logic                busy;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata, busy
    );

    // Requester / memory side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                     |
// | Purpose  : Shares one single-port memory between fetch and load/store      |
// |            ports, one access in flight, fixed read latency MEM_LAT.        |
// |            Define ARB_FIXED_PRIO_EN for fixed D-over-I priority            |
// |            (round-robin otherwise).                                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int WORD_LEN = 32,
    parameter int MEM_LAT  = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [3:0] c_LAT_LOAD = 4'(MEM_LAT - 1);
    localparam bit         c_HAS_WAIT = (MEM_LAT > 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_owner_d;
    logic                r_owner_we;
    logic [3:0]          r_lat_cnt;
    logic [WORD_LEN-1:0] r_m_addr;
    logic [WORD_LEN-1:0] r_m_wdata;
    logic [WORD_LEN-1:0] r_i_rdata;
    logic [WORD_LEN-1:0] r_d_rdata;
    logic                r_m_en;
    logic                r_m_we;
    logic                r_i_gnt;
    logic                r_d_gnt;
    logic                r_i_rvalid;
    logic                r_d_rvalid;

    logic                w_any_req;
    logic                w_tie_d;
    logic                w_pick_d;
    logic                w_accept;
    logic                w_m_en_nxt;
    logic                w_m_we_nxt;
    logic                w_i_gnt_nxt;
    logic                w_d_gnt_nxt;
    logic                w_i_rvalid_nxt;
    logic                w_d_rvalid_nxt;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
    assign w_tie_d = 1'b1;
`else
    logic r_last_owner_d;

    // Reset to the fetch port so the load/store port wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_owner_d <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            r_last_owner_d <= r_owner_d;
        end
    end

    assign w_tie_d = ~r_last_owner_d;
`endif

    assign w_any_req = bus.i_req | bus.d_req;
    assign w_pick_d  = bus.d_req & (~bus.i_req | w_tie_d);
    assign w_accept  = (r_state == S_IDLE) & w_any_req;

    // ------------------------------------------------------------------
    // Next-state and next-output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_m_en_nxt     = 1'b0;
        w_m_we_nxt     = 1'b0;
        w_i_gnt_nxt    = 1'b0;
        w_d_gnt_nxt    = 1'b0;
        w_i_rvalid_nxt = 1'b0;
        w_d_rvalid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ACCESS;
                    w_m_en_nxt  = 1'b1;
                    w_m_we_nxt  = w_pick_d & bus.d_we;
                    w_i_gnt_nxt = ~w_pick_d;
                    w_d_gnt_nxt = w_pick_d;
                end
            end
            S_ACCESS: begin
                w_state_nxt = c_HAS_WAIT ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (r_lat_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt    = S_IDLE;
                w_i_rvalid_nxt = ~r_owner_d;
                w_d_rvalid_nxt = r_owner_d;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered pulse outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_m_en     <= 1'b0;
            r_m_we     <= 1'b0;
            r_i_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_m_en     <= w_m_en_nxt;
            r_m_we     <= w_m_we_nxt;
            r_i_gnt    <= w_i_gnt_nxt;
            r_d_gnt    <= w_d_gnt_nxt;
            r_i_rvalid <= w_i_rvalid_nxt;
            r_d_rvalid <= w_d_rvalid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Access payload latch, latency counter and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_d  <= 1'b0;
            r_owner_we <= 1'b0;
            r_lat_cnt  <= 4'd0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_owner_d  <= w_pick_d;
                r_owner_we <= w_pick_d & bus.d_we;
                r_m_addr   <= w_pick_d ? bus.d_addr : bus.i_addr;
                r_m_wdata  <= w_pick_d ? bus.d_wdata : '0;
            end
            if (r_state == S_ACCESS) begin
                r_lat_cnt <= c_LAT_LOAD;
            end else if (r_state == S_WAIT) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            // Stores acknowledge with zero data; memory read data is ignored
            if (r_state == S_RESP) begin
                if (r_owner_d) begin
                    r_d_rdata <= r_owner_we ? '0 : bus.m_rdata;
                end else begin
                    r_i_rdata <= bus.m_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.m_en     = r_m_en;
    assign bus.m_we     = r_m_we;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.i_gnt    = r_i_gnt;
    assign bus.d_gnt    = r_d_gnt;
    assign bus.i_rvalid = r_i_rvalid;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.d_rdata  = r_d_rdata;
    // Busy spans the grant cycle through the response pulse
    assign bus.busy     = (r_state != S_IDLE) | r_i_rvalid | r_d_rvalid;

endmodule
`default_nettype wire
